rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) stage and a long-latency execution unit (LU), e.g. multiplier or divider.
- WB always wins. LU results are buffered in a small FIFO and drained on idle WB cycles.
- A per-register scoreboard tracks outstanding LU results for the hazard unit.
- A WB write to a register with an outstanding LU result kills that stale LU result (WAW protection).

Parameters:
DEPTH, 4, LU result FIFO entries (power of 2, ≥2)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
wb_en  in  1  WB stage write request (cannot be stalled)
wb_dest  in  4  WB destination register
wb_value  in  32  WB data
lu_iss_en  in  1  LU operation issued this cycle
lu_iss_dest  in  4  destination of the issued LU operation
lu_valid  in  1  LU result valid
lu_ready  out  1  arbiter can accept an LU result
lu_dest  in  4  LU result destination
lu_value  in  32  LU result data
rf_wr_en  out  1  register file write enable
rf_wr_dest  out  4  register file write address
rf_wr_value  out  32  register file write data
busy  out  15  busy[i]=1: LU result for Ri outstanding

Behaviour:
- Reset (rst=0 at a rising edge): rf_wr_en=0, rf_wr_dest=0, rf_wr_value=0, busy=0, kill=0, FIFO empty. lu_ready=1 after reset.
- Destination 15 (PC) is never written. Requests with dest 15 are dropped and have no scoreboard effect.
- Output stage is registered. Selection is evaluated at edge t and rf_wr_* is valid during cycle t+1.
  - Priority 1: wb_en=1 → rf_wr_* = wb_*, 1-cycle latency.
  - Priority 2: otherwise, FIFO head if non-empty and head valid → written, popped.
  - An invalidated head is popped without a write.
  - Otherwise rf_wr_en=0.
- LU handshake:
  - lu_ready = (count < DEPTH), combinational from count.
  - An accept is lu_valid & lu_ready. The entry is pushed at that edge.
  - lu_valid/lu_dest/lu_value must hold until accepted.
  - The FIFO head is the only LU source, so minimum LU latency is 2 cycles (accept → head → write).
  - Simultaneous push and pop in the same cycle is allowed. Count is unchanged.
  - When full, no push occurs even if a pop happens the same cycle, because ready is already 0.
- Scoreboard:
  - lu_iss_en sets busy[lu_iss_dest] at the edge.
  - busy[d] clears when the LU result for d leaves the FIFO, either written or discarded.
  - Issue to an already-busy register is illegal. It is guarded by the hazard unit and is not checked here.
- WAW kill:
  - If wb_en with dest d and busy[d]=1, every valid FIFO entry with dest d is invalidated.
  - If no FIFO entry for d exists, kill[d] is set.
  - An LU result accepted for d while kill[d]=1 is pushed already invalid, and kill[d] clears.
- Same-cycle accept plus WB to the same d: the incoming entry is pushed invalid.
- Same-cycle issue and result for the same d (0-latency) is illegal.
- Reset mid-operation: all buffered LU results and busy bits are discarded. No write occurs in the cycle after reset.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined: adds outputs stall_cnt[CNT_W] and drop_cnt[CNT_W], both reset to 0 and saturating at all-ones.
  - stall_cnt increments each cycle the FIFO holds a valid head and wb_en=1.
  - drop_cnt increments each time an invalid entry is popped.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset with wb_en=1 held → rf_wr_en=0, busy=0, lu_ready=1 on the first cycle after rst rises.
- wb_en=1, dest 3, value 0xDEADBEEF at t → rf_wr_en=1, dest 3, value 0xDEADBEEF during t+1.
- Issue R5, LU result R5=0x55 accepted while wb_en=1 for 3 cycles → R5 written 1 cycle after wb_en drops; busy[5] falls the same edge.
- Push DEPTH=4 LU results while wb_en is held high → lu_ready=0 after 4 accepts. Drop wb_en → results are written in order, one per cycle, and lu_ready rises after the first pop.
- Issue R7, then WB writes R7=0x11 before the LU result arrives; the LU result R7=0x99 then arrives → no write of 0x99, busy[7] clears, and with RF_ARB_STATS_EN drop_cnt=1.
- WB write and LU result both to dest 15 → rf_wr_en stays 0 and busy is unchanged.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, LU results queue in a FIFO with WAW kill.
// Define RF_ARB_STATS_EN to add the stall_cnt/drop_cnt saturating statistics outputs.
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [3:0]       wb_dest,
    input  logic [31:0]      wb_value,
    input  logic             lu_iss_en,
    input  logic [3:0]       lu_iss_dest,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [3:0]       lu_dest,
    input  logic [31:0]      lu_value,
    output logic             rf_wr_en,
    output logic [3:0]       rf_wr_dest,
    output logic [31:0]      rf_wr_value,
    output logic [14:0]      busy
`ifdef RF_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [3:0] PC = 4'd15;

    logic [3:0]       q_dest  [DEPTH];
    logic [31:0]      q_value [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [15:0]      busy_q, kill_q;
    logic [15:0]      busy_d, kill_d;

    logic wb_act, accept, push, push_vld, pop, head_vld, waw, kill_set;
    logic [DEPTH-1:0] hit;
    logic [PTR_W-1:0] offs;

    assign lu_ready = count < (PTR_W+1)'(DEPTH);
    assign busy     = busy_q[14:0];
    assign head_vld = q_vld[rd_ptr];

    always_comb begin
        wb_act   = wb_en && (wb_dest != PC);
        accept   = lu_valid && lu_ready;
        push     = accept && (lu_dest != PC);
        push_vld = !kill_q[lu_dest] && !(wb_act && (wb_dest == lu_dest));
        pop      = !wb_en && (count != '0);
        waw      = wb_act && busy_q[wb_dest];
        hit      = '0;
        offs     = '0;
        // Only occupied slots (distance from head below count) take part in the kill search
        for (int i = 0; i < DEPTH; i++) begin
            offs   = PTR_W'(i) - rd_ptr;
            hit[i] = ({1'b0, offs} < count) && (q_dest[i] == wb_dest);
        end
        kill_set = waw && !(|hit) && !(push && (lu_dest == wb_dest));

        busy_d = busy_q;
        if (pop)
            busy_d[q_dest[rd_ptr]] = 1'b0;
        if (lu_iss_en && (lu_iss_dest != PC))
            busy_d[lu_iss_dest] = 1'b1;
        busy_d[15] = 1'b0;

        kill_d = kill_q;
        if (push)
            kill_d[lu_dest] = 1'b0;
        if (kill_set)
            kill_d[wb_dest] = 1'b1;
        kill_d[15] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wr_en    <= 1'b0;
            rf_wr_dest  <= '0;
            rf_wr_value <= '0;
            busy_q      <= '0;
            kill_q      <= '0;
            q_vld       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            busy_q <= busy_d;
            kill_q <= kill_d;

            if (wb_act) begin
                rf_wr_en    <= 1'b1;
                rf_wr_dest  <= wb_dest;
                rf_wr_value <= wb_value;
            end else if (pop && head_vld) begin
                rf_wr_en    <= 1'b1;
                rf_wr_dest  <= q_dest[rd_ptr];
                rf_wr_value <= q_value[rd_ptr];
            end else begin
                rf_wr_en    <= 1'b0;
            end

            if (waw) begin
                for (int i = 0; i < DEPTH; i++)
                    if (hit[i])
                        q_vld[i] <= 1'b0;
            end
            // The write slot is never occupied while pushing, so it cannot collide with the kill
            if (push) begin
                q_dest[wr_ptr]  <= lu_dest;
                q_value[wr_ptr] <= lu_value;
                q_vld[wr_ptr]   <= push_vld;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if ((count != '0) && head_vld && wb_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (pop && !head_vld && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
